// File: rtl/regdump_pkg.sv
// Shared types and default sizing for the run-then-dump register sequencer.
package regdump_pkg;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_REG_W    = 5;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_CYC_W    = 10;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    RUN,
    DUMP,
    DONE
  } regdump_state_t;
endpackage

// File: rtl/regdump_cycle_counter.sv
// Run-length counter: an up count for reporting plus a loadable down count
// whose compare against one flags the final counted cycle.
module regdump_cycle_counter
  import regdump_pkg::*;
#(
  parameter int CYC_W = DEF_CYC_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CYC_W-1:0] load_val,
  input  logic             clear,
  input  logic             enable,
  output logic [CYC_W-1:0] count,
  output logic             hit,
  output logic             zero
);

  logic [CYC_W-1:0] remaining;

  always_ff @(posedge clock) begin
    if (reset) begin
      count     <= '0;
      remaining <= '0;
    end else begin
      if (clear)
        count <= '0;
      else if (enable)
        count <= count + 1'b1;

      if (load)
        remaining <= load_val;
      else if (enable)
        remaining <= remaining - 1'b1;
    end
  end

  // One cycle left means this enabled cycle brings count up to the loaded value.
  assign hit  = enable && (remaining == CYC_W'(1));
  assign zero = (remaining == '0);

endmodule

// File: rtl/regdump_sequencer.sv
// Resets the processor, runs it for a programmed cycle count, then sweeps the
// register file out over valid/ready. Optional checker under REGDUMP_CHECK_EN.
module regdump_sequencer
  import regdump_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int REG_W    = DEF_REG_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int CYC_W    = DEF_CYC_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [CYC_W-1:0]  num_cycles,
  input  logic [REG_W-1:0]  proc_rs1,
  output logic [REG_W-1:0]  rs1_out,
  input  logic [DATA_W-1:0] reg_data,
  output logic              cpu_reset,
  output logic              run,
  output logic              test_mode,
  output logic [CYC_W-1:0]  cycle_count,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [REG_W-1:0]  dump_idx,
  output logic [DATA_W-1:0] dump_data,
`ifdef REGDUMP_CHECK_EN
  input  logic [DATA_W-1:0] exp_data,
  output logic              mismatch,
  output logic [REG_W:0]    error_count,
`endif
  output logic              done
);

  regdump_state_t state;
  logic           accept;
  logic           xfer;
  logic           last_idx;
  logic           cnt_hit;
  logic           cnt_zero;

  assign accept   = start && ((state == IDLE) || (state == DONE));
  assign xfer     = dump_valid && dump_ready;
  assign last_idx = (dump_idx == REG_W'(NUM_REGS - 1));

  regdump_cycle_counter #(
    .CYC_W(CYC_W)
  ) u_cycle_counter (
    .clock    (clock),
    .reset    (reset),
    .load     (accept),
    .load_val (num_cycles),
    .clear    (accept),
    .enable   (state == RUN),
    .count    (cycle_count),
    .hit      (cnt_hit),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cpu_reset  <= 1'b0;
      run        <= 1'b0;
      test_mode  <= 1'b0;
      dump_valid <= 1'b0;
      dump_idx   <= '0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= CLR;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
          end
        end
        CLR: begin
          cpu_reset <= 1'b0;
          if (cnt_zero) begin
            state      <= DUMP;
            test_mode  <= 1'b1;
            dump_valid <= 1'b1;
          end else begin
            state <= RUN;
            run   <= 1'b1;
          end
        end
        RUN: begin
          if (cnt_hit) begin
            state      <= DUMP;
            run        <= 1'b0;
            test_mode  <= 1'b1;
            dump_valid <= 1'b1;
          end
        end
        DUMP: begin
          if (xfer) begin
            if (last_idx) begin
              state      <= DONE;
              dump_idx   <= '0;
              test_mode  <= 1'b0;
              dump_valid <= 1'b0;
              done       <= 1'b1;
            end else begin
              dump_idx <= dump_idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read port A is borrowed from the processor only while dumping.
  assign rs1_out   = test_mode ? dump_idx : proc_rs1;
  assign dump_data = dump_valid ? reg_data : '0;

`ifdef REGDUMP_CHECK_EN
  logic data_bad;

  assign data_bad = xfer && (exp_data != dump_data);

  always_ff @(posedge clock) begin
    if (reset) begin
      mismatch    <= 1'b0;
      error_count <= '0;
    end else begin
      mismatch <= data_bad;
      if (accept)
        error_count <= '0;
      else if (data_bad)
        error_count <= error_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_regdump_sequencer.sv
// Self-checking bench for regdump_sequencer; covers REGDUMP_CHECK_EN when defined.
module tb_regdump_sequencer;
  localparam int NUM_REGS = 32;
  localparam int REG_W    = 5;
  localparam int DATA_W   = 32;
  localparam int CYC_W    = 10;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [CYC_W-1:0]  num_cycles = '0;
  logic [REG_W-1:0]  proc_rs1 = '0;
  logic [REG_W-1:0]  rs1_out;
  logic [DATA_W-1:0] reg_data;
  logic              cpu_reset;
  logic              run;
  logic              test_mode;
  logic [CYC_W-1:0]  cycle_count;
  logic              dump_valid;
  logic              dump_ready = 1'b0;
  logic [REG_W-1:0]  dump_idx;
  logic [DATA_W-1:0] dump_data;
  logic              done;
  logic [4:0]        ctl;
`ifdef REGDUMP_CHECK_EN
  logic [DATA_W-1:0] exp_data;
  logic              mismatch;
  logic [REG_W:0]    error_count;
  logic              chk_on = 1'b0;
`endif

  logic [DATA_W-1:0] regs [NUM_REGS];
  int checks   = 0;
  int failures = 0;

  assign reg_data = regs[rs1_out];
  assign ctl      = {cpu_reset, run, test_mode, dump_valid, done};
`ifdef REGDUMP_CHECK_EN
  assign exp_data = (chk_on && (rs1_out == REG_W'(3) || rs1_out == REG_W'(17))) ? ~reg_data : reg_data;
`endif

  regdump_sequencer #(
    .NUM_REGS(NUM_REGS), .REG_W(REG_W), .DATA_W(DATA_W), .CYC_W(CYC_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .num_cycles  (num_cycles),
    .proc_rs1    (proc_rs1),
    .rs1_out     (rs1_out),
    .reg_data    (reg_data),
    .cpu_reset   (cpu_reset),
    .run         (run),
    .test_mode   (test_mode),
    .cycle_count (cycle_count),
    .dump_valid  (dump_valid),
    .dump_ready  (dump_ready),
    .dump_idx    (dump_idx),
    .dump_data   (dump_data),
`ifdef REGDUMP_CHECK_EN
    .exp_data    (exp_data),
    .mismatch    (mismatch),
    .error_count (error_count),
`endif
    .done        (done)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    proc_rs1 = REG_W'($urandom);
    #1;
  endtask

  task automatic fill_regs();
    for (int i = 0; i < NUM_REGS; i++) regs[i] = $urandom;
  endtask

  task automatic drain_to_done(output bit ok);
    int budget = 300;
    dump_ready = 1'b1;
    while (done !== 1'b1 && budget > 0) begin
      tick();
      budget--;
    end
    ok = (done === 1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (ctl !== 5'b0 || cycle_count !== '0 || dump_idx !== '0 || dump_data !== '0 || rs1_out !== proc_rs1) begin
      failures++;
      $display("FAIL reset_state ctl=%b count=%0d idx=%0d data=%h rs1=%0d required ctl=00000 count=0 idx=0 data=0 rs1=%0d",
               ctl, cycle_count, dump_idx, dump_data, rs1_out, proc_rs1);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (ctl !== 5'b0 || rs1_out !== proc_rs1) begin
      failures++;
      $display("FAIL idle_state ctl=%b rs1=%0d required ctl=00000 rs1=%0d", ctl, rs1_out, proc_rs1);
    end
  endtask

  task automatic test_basic_run(input int n);
    fill_regs();
    dump_ready = 1'b1;
    start = 1'b1;
    num_cycles = CYC_W'(n);
    tick();
    start = 1'b0;
    num_cycles = CYC_W'($urandom);
    checks++;
    if (ctl !== 5'b10000 || cycle_count !== '0) begin
      failures++;
      $display("FAIL clr_cycle n=%0d ctl=%b count=%0d required ctl=10000 count=0", n, ctl, cycle_count);
    end
    for (int k = 0; k < n; k++) begin
      tick();
      checks++;
      if (ctl !== 5'b01000 || cycle_count !== CYC_W'(k)) begin
        failures++;
        $display("FAIL run_cycle n=%0d k=%0d ctl=%b count=%0d required ctl=01000 count=%0d", n, k, ctl, cycle_count, k);
      end
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      tick();
      checks++;
      if (ctl !== 5'b00110 || dump_idx !== REG_W'(i) || rs1_out !== REG_W'(i) ||
          dump_data !== regs[i] || cycle_count !== CYC_W'(n)) begin
        failures++;
        $display("FAIL dump_beat n=%0d i=%0d ctl=%b idx=%0d rs1=%0d data=%h count=%0d required ctl=00110 idx=%0d data=%h count=%0d",
                 n, i, ctl, dump_idx, rs1_out, dump_data, cycle_count, i, regs[i], n);
      end
    end
    tick();
    checks++;
    if (ctl !== 5'b00001 || dump_data !== '0 || rs1_out !== proc_rs1 || cycle_count !== CYC_W'(n)) begin
      failures++;
      $display("FAIL done_state n=%0d ctl=%b data=%h rs1=%0d count=%0d required ctl=00001 data=0 rs1=%0d count=%0d",
               n, ctl, dump_data, rs1_out, cycle_count, proc_rs1, n);
    end
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] held;
    bit ok;
    fill_regs();
    dump_ready = 1'b1;
    start = 1'b1;
    num_cycles = CYC_W'(2);
    tick();
    start = 1'b0;
    repeat (2) tick();
    for (int i = 0; i <= 5; i++) tick();
    checks++;
    if (dump_valid !== 1'b1 || dump_idx !== REG_W'(5)) begin
      failures++;
      $display("FAIL bp_reach valid=%b idx=%0d required valid=1 idx=5", dump_valid, dump_idx);
    end
    held = regs[5];
    dump_ready = 1'b0;
    for (int c = 0; c < 7; c++) begin
      tick();
      checks++;
      if (dump_valid !== 1'b1 || dump_idx !== REG_W'(5) || rs1_out !== REG_W'(5) || dump_data !== held) begin
        failures++;
        $display("FAIL bp_stall c=%0d valid=%b idx=%0d rs1=%0d data=%h required valid=1 idx=5 rs1=5 data=%h",
                 c, dump_valid, dump_idx, rs1_out, dump_data, held);
      end
    end
    dump_ready = 1'b1;
    tick();
    checks++;
    if (dump_idx !== REG_W'(6) || dump_data !== regs[6]) begin
      failures++;
      $display("FAIL bp_resume idx=%0d data=%h required idx=6 data=%h", dump_idx, dump_data, regs[6]);
    end
    drain_to_done(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL bp_drain done=%b required done=1 within budget", done);
    end
  endtask

  task automatic test_random_ready();
    int n = $urandom_range(1, 15);
    int exp_idx = 0;
    fill_regs();
    dump_ready = 1'b0;
    start = 1'b1;
    num_cycles = CYC_W'(n);
    tick();
    start = 1'b0;
    repeat (n) tick();
    while (exp_idx < NUM_REGS) begin
      tick();
      checks++;
      if (dump_valid !== 1'b1 || done !== 1'b0 || dump_idx !== REG_W'(exp_idx) || dump_data !== regs[exp_idx]) begin
        failures++;
        $display("FAIL rand_ready valid=%b done=%b idx=%0d data=%h required valid=1 done=0 idx=%0d data=%h",
                 dump_valid, done, dump_idx, dump_data, exp_idx, regs[exp_idx]);
      end
      dump_ready = 1'($urandom_range(0, 1));
      if (dump_ready) exp_idx++;
    end
    tick();
    checks++;
    if (done !== 1'b1 || dump_valid !== 1'b0) begin
      failures++;
      $display("FAIL rand_done done=%b valid=%b required done=1 valid=0", done, dump_valid);
    end
  endtask

  task automatic test_restart_ignored_start();
    int runs = 0;
    int resets = 0;
    int budget = 100;
    int i = 0;
    bit ok;
    fill_regs();
    start = 1'b1;
    num_cycles = CYC_W'(6);
    tick();
    start = 1'b0;
    while (dump_valid !== 1'b1 && budget > 0) begin
      tick();
      budget--;
      i++;
      if (run === 1'b1) runs++;
      if (cpu_reset === 1'b1) resets++;
      if (i == 2) begin
        start = 1'b1;
        num_cycles = CYC_W'(50);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    checks++;
    if (runs != 6 || resets != 0 || cycle_count !== CYC_W'(6) || dump_valid !== 1'b1) begin
      failures++;
      $display("FAIL ignored_start runs=%0d resets=%0d count=%0d valid=%b required runs=6 resets=0 count=6 valid=1",
               runs, resets, cycle_count, dump_valid);
    end
    drain_to_done(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL restart_drain done=%b required done=1 within budget", done);
    end
    start = 1'b1;
    num_cycles = CYC_W'(3);
    tick();
    start = 1'b0;
    checks++;
    if (ctl !== 5'b10000 || cycle_count !== '0) begin
      failures++;
      $display("FAIL restart_clr ctl=%b count=%0d required ctl=10000 count=0", ctl, cycle_count);
    end
    runs = 0;
    repeat (3) begin
      tick();
      if (run === 1'b1) runs++;
    end
    tick();
    checks++;
    if (runs != 3 || dump_valid !== 1'b1 || cycle_count !== CYC_W'(3)) begin
      failures++;
      $display("FAIL restart_run runs=%0d valid=%b count=%0d required runs=3 valid=1 count=3", runs, dump_valid, cycle_count);
    end
    drain_to_done(ok);
  endtask

  task automatic test_reset_mid_run();
    start = 1'b1;
    num_cycles = CYC_W'(255);
    tick();
    start = 1'b0;
    repeat (40) tick();
    checks++;
    if (run !== 1'b1 || cycle_count !== CYC_W'(39)) begin
      failures++;
      $display("FAIL mid_run_pre run=%b count=%0d required run=1 count=39", run, cycle_count);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (ctl !== 5'b0 || rs1_out !== proc_rs1 || cycle_count !== '0) begin
      failures++;
      $display("FAIL mid_run_abort ctl=%b rs1=%0d count=%0d required ctl=00000 rs1=%0d count=0", ctl, rs1_out, cycle_count, proc_rs1);
    end
    dump_ready = 1'b1;
    start = 1'b1;
    num_cycles = CYC_W'(1);
    tick();
    start = 1'b0;
    repeat (5) tick();
    checks++;
    if (test_mode !== 1'b1 || rs1_out !== REG_W'(3)) begin
      failures++;
      $display("FAIL mid_dump_pre test_mode=%b rs1=%0d required test_mode=1 rs1=3", test_mode, rs1_out);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (ctl !== 5'b0 || rs1_out !== proc_rs1 || dump_idx !== '0) begin
      failures++;
      $display("FAIL mid_dump_abort ctl=%b rs1=%0d idx=%0d required ctl=00000 rs1=%0d idx=0", ctl, rs1_out, dump_idx, proc_rs1);
    end
  endtask

`ifdef REGDUMP_CHECK_EN
  task automatic test_checker();
    int pulses = 0;
    int budget = 200;
    bit ok;
    fill_regs();
    chk_on = 1'b1;
    dump_ready = 1'b1;
    start = 1'b1;
    num_cycles = CYC_W'(2);
    tick();
    start = 1'b0;
    while (done !== 1'b1 && budget > 0) begin
      tick();
      budget--;
      if (mismatch === 1'b1) pulses++;
    end
    tick();
    if (mismatch === 1'b1) pulses++;
    checks++;
    if (pulses != 2 || error_count !== 6'd2) begin
      failures++;
      $display("FAIL checker_count pulses=%0d errors=%0d required pulses=2 errors=2", pulses, error_count);
    end
    chk_on = 1'b0;
    start = 1'b1;
    num_cycles = CYC_W'(4);
    tick();
    start = 1'b0;
    checks++;
    if (cpu_reset !== 1'b1 || error_count !== '0) begin
      failures++;
      $display("FAIL checker_clear cpu_reset=%b errors=%0d required cpu_reset=1 errors=0", cpu_reset, error_count);
    end
    drain_to_done(ok);
    checks++;
    if (!ok || error_count !== '0) begin
      failures++;
      $display("FAIL checker_clean done=%b errors=%0d required done=1 errors=0", done, error_count);
    end
  endtask
`endif

  initial begin
    fill_regs();
    test_reset();
    test_basic_run(10);
    test_basic_run($urandom_range(1, 20));
    test_basic_run(0);
    test_backpressure();
    test_random_ready();
    test_restart_ignored_start();
    test_reset_mid_run();
`ifdef REGDUMP_CHECK_EN
    test_checker();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
